// File: rtl/input_stream_loader.sv
// Input stream loader: walks a FIFO of stream words and splits them into
// k-d tree internal nodes, leaf patches and query patches, emitting one
// single-cycle write strobe per completed record.

// One patch word holding register; instances form the patch staging buffer.
module input_stream_loader_slot #(
  parameter int DATA_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Capture the popped word when this slot is the current word position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

module input_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             load_kdtree,
  input  logic                             fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  output logic                             fifo_deq,
  output logic                             int_node_wen,
  output logic [5:0]                       int_node_addr,
  output logic [2:0]                       int_node_idx,
  output logic [DATA_WIDTH-1:0]            int_node_median,
  output logic                             leaf_wen,
  output logic [5:0]                       leaf_addr,
  output logic [2:0]                       leaf_patch_sel,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_data,
  output logic [DATA_WIDTH-1:0]            leaf_patch_idx,
  output logic                             query_wen,
  output logic [8:0]                       query_addr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_data,
  output logic                             kdtree_loaded,
  output logic                             queries_loaded
);

  // Word position counter must reach PATCH_SIZE (the leaf patch index word).
  localparam int SW = $clog2(PATCH_SIZE + 1);

  typedef enum logic [2:0] {IDLE, NODES, LEAVES, QUERIES, DONE} state_t;

  state_t                                state;
  logic [SW-1:0]                         word_sel;
  logic [5:0]                            node_cnt;
  logic [5:0]                            leaf_cnt;
  logic [2:0]                            patch_cnt;
  logic [8:0]                            query_cnt;
  logic [2:0]                            idx_hold;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] slot_q;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] slot_next;
  logic                                  node_last;
  logic                                  leaf_last;
  logic                                  query_last;
  logic                                  patch_phase;

  assign patch_phase = (state == LEAVES) || (state == QUERIES);
  assign node_last   = (node_cnt == 6'(NUM_LEAVES - 2));
  assign leaf_last   = (leaf_cnt == 6'(NUM_LEAVES - 1)) && (patch_cnt == 3'(LEAF_SIZE - 1));
  assign query_last  = (query_cnt == 9'(NUM_QUERYS - 1));

  // Pop whenever a loading state has data; a start pulse wins over popping.
  always_comb begin
    fifo_deq = 1'b0;
    if (!load_kdtree && fifo_rempty_n &&
        (state == NODES || state == LEAVES || state == QUERIES))
      fifo_deq = 1'b1;
  end

  // Patch staging buffer: one slot per data word, word 0 ends up at the LSB.
  // slot_next shows the buffer including a word popped this cycle, so a
  // query can be written out on the same edge its last word arrives.
  for (genvar k = 0; k < PATCH_SIZE; k++) begin : g_slot
    logic slot_ld;
    assign slot_ld = fifo_deq && patch_phase && (word_sel == SW'(k));
    input_stream_loader_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk  (wb_clk_i),
      .rst  (wb_rst_i),
      .load (slot_ld),
      .d    (fifo_rdata),
      .q    (slot_q[k])
    );
    assign slot_next[k] = slot_ld ? fifo_rdata : slot_q[k];
  end

  // Main sequencer: counters, registered strobes, record outputs and flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      word_sel        <= '0;
      node_cnt        <= '0;
      leaf_cnt        <= '0;
      patch_cnt       <= '0;
      query_cnt       <= '0;
      idx_hold        <= '0;
      int_node_wen    <= 1'b0;
      int_node_addr   <= '0;
      int_node_idx    <= '0;
      int_node_median <= '0;
      leaf_wen        <= 1'b0;
      leaf_addr       <= '0;
      leaf_patch_sel  <= '0;
      leaf_data       <= '0;
      leaf_patch_idx  <= '0;
      query_wen       <= 1'b0;
      query_addr      <= '0;
      query_data      <= '0;
      kdtree_loaded   <= 1'b0;
      queries_loaded  <= 1'b0;
    end else begin
      int_node_wen <= 1'b0;
      leaf_wen     <= 1'b0;
      query_wen    <= 1'b0;
      if (load_kdtree) begin
        // Restart from scratch; any partial record is abandoned.
        state          <= NODES;
        word_sel       <= '0;
        node_cnt       <= '0;
        leaf_cnt       <= '0;
        patch_cnt      <= '0;
        query_cnt      <= '0;
        kdtree_loaded  <= 1'b0;
        queries_loaded <= 1'b0;
      end else if (fifo_deq) begin
        case (state)
          NODES: begin
            if (word_sel == '0) begin
              idx_hold <= fifo_rdata[2:0];
              word_sel <= SW'(1);
            end else begin
              word_sel        <= '0;
              int_node_wen    <= 1'b1;
              int_node_addr   <= node_cnt;
              int_node_idx    <= idx_hold;
              int_node_median <= fifo_rdata;
              node_cnt        <= node_cnt + 6'd1;
              if (node_last) state <= LEAVES;
            end
          end
          LEAVES: begin
            if (word_sel == SW'(PATCH_SIZE)) begin
              word_sel       <= '0;
              leaf_wen       <= 1'b1;
              leaf_addr      <= leaf_cnt;
              leaf_patch_sel <= patch_cnt;
              leaf_data      <= slot_q;
              leaf_patch_idx <= fifo_rdata;
              if (patch_cnt == 3'(LEAF_SIZE - 1)) begin
                patch_cnt <= '0;
                leaf_cnt  <= leaf_cnt + 6'd1;
              end else begin
                patch_cnt <= patch_cnt + 3'd1;
              end
              if (leaf_last) begin
                state         <= QUERIES;
                kdtree_loaded <= 1'b1;
              end
            end else begin
              word_sel <= word_sel + SW'(1);
            end
          end
          QUERIES: begin
            if (word_sel == SW'(PATCH_SIZE - 1)) begin
              word_sel   <= '0;
              query_wen  <= 1'b1;
              query_addr <= query_cnt;
              query_data <= slot_next;
              query_cnt  <= query_cnt + 9'd1;
              if (query_last) begin
                state          <= DONE;
                queries_loaded <= 1'b1;
              end
            end else begin
              word_sel <= word_sel + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/input_stream_loader.md
INPUT_STREAM_LOADER -- requirements
Module: input_stream_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, width of one stream word.
REQ-002 SHALL have parameter PATCH_SIZE, default 5, data words per patch.
REQ-003 SHALL have parameter LEAF_SIZE, default 8, patches per leaf.
REQ-004 SHALL have parameter NUM_LEAVES, default 64; internal node count is NUM_LEAVES-1.
REQ-005 SHALL have parameter NUM_QUERYS, default 494, query patches per image.
REQ-006 SHALL have ports: wb_clk_i in 1, sole clock; wb_rst_i in 1, asynchronous active-high reset.
REQ-007 SHALL have load_kdtree in 1, single-cycle start pulse; fifo_rempty_n in 1, input FIFO holds data; fifo_rdata in DATA_WIDTH, first-word-fall-through head word; fifo_deq out 1, pop.
REQ-008 SHALL have int_node_wen out 1; int_node_addr out 6; int_node_idx out 3, split dimension; int_node_median out DATA_WIDTH.
REQ-009 SHALL have leaf_wen out 1; leaf_addr out 6; leaf_patch_sel out 3; leaf_data out PATCH_SIZE*DATA_WIDTH; leaf_patch_idx out DATA_WIDTH.
REQ-010 SHALL have query_wen out 1; query_addr out 9; query_data out PATCH_SIZE*DATA_WIDTH.
REQ-011 SHALL have kdtree_loaded out 1 and queries_loaded out 1, level status flags.

Function
REQ-012 SHALL implement states IDLE, NODES, LEAVES, QUERIES, DONE.
REQ-013 SHALL assert fifo_deq combinationally iff state is NODES/LEAVES/QUERIES and fifo_rempty_n=1; a word is consumed in every cycle fifo_deq=1.
REQ-014 SHALL, on load_kdtree=1 in any state, go to NODES next cycle, clear all counters, kdtree_loaded and queries_loaded; a word present in that same cycle SHALL NOT be popped.
REQ-015 NODES: word pairs (index, median); index word low 3 bits captured; on median pop, int_node_wen=1 the next cycle with addr=node counter, counter++.
REQ-016 SHALL leave NODES after 2*(NUM_LEAVES-1)=126 words, entering LEAVES on the cycle after the last pop.
REQ-017 LEAVES: groups of PATCH_SIZE+1 words; data word k placed at leaf_data[k*DATA_WIDTH +: DATA_WIDTH] (word 0 at LSB); final word is leaf_patch_idx.
REQ-018 SHALL pulse leaf_wen one cycle after the group's last pop with leaf_addr=leaf counter, leaf_patch_sel=patch counter; patch counter wraps 7->0 incrementing leaf counter.
REQ-019 SHALL after NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1)=3072 words enter QUERIES and set kdtree_loaded=1 coincident with the final leaf_wen.
REQ-020 QUERIES: groups of PATCH_SIZE words packed as REQ-017; query_wen pulses one cycle after fifth pop, query_addr=query counter 0..NUM_QUERYS-1.
REQ-021 SHALL after NUM_QUERYS*PATCH_SIZE=2470 words enter DONE, set queries_loaded=1 coincident with final query_wen; DONE pops nothing and holds flags until load_kdtree or reset.
REQ-022 Empty FIFO mid-group SHALL stall without losing partial words; no write strobe while stalled.
REQ-023 Write strobes SHALL be single-cycle; data/addr outputs SHALL be stable while strobe high.
REQ-024 Data outputs SHALL hold last written values when strobes are low.

Reset
REQ-025 wb_rst_i=1 SHALL asynchronously force IDLE, all counters 0, all outputs 0 (fifo_deq 0, flags 0, data/addr 0).
REQ-026 Reset mid-load SHALL discard partial groups; loading resumes only after a new load_kdtree.
REQ-027 In IDLE without load_kdtree, FIFO data SHALL remain unpopped.

Verification
REQ-028 Full image: load_kdtree, stream 126+3072+2470 words back-to-back -> 63 int_node_wen, 512 leaf_wen, 494 query_wen, final query_addr=493, queries_loaded=1, total pops 5668.
REQ-029 Node pair (3, 1023) first -> int_node_wen cycle after second pop, addr 0, idx 3, median 1023.
REQ-030 Leaf group words 1,2,3,4,5,77 for patch 9 of leaf 1 -> leaf_wen, addr 1, patch_sel 1, leaf_data LSB word 1, MSB word 5, patch_idx 77.
REQ-031 Random fifo_rempty_n gaps (50% duty) -> identical write sequence as REQ-028, no strobe during stalls.
REQ-032 load_kdtree asserted after 200 leaf words -> next node write at addr 0, kdtree_loaded 0, prior partial leaf dropped.
REQ-033 wb_rst_i pulse mid-QUERIES -> all outputs 0 immediately, fifo_deq stays 0 until load_kdtree.
